// File: rtl/mvp_matrix_sequencer.sv
// Builds MVP = P*V*M on one shared external 4x4 multiplier and caches P*V between jobs.
// Optional watchdog and o_err strobe: define MVP_SEQ_TIMEOUT_EN.
module mvp_matrix_sequencer #(
    parameter int unsigned DATAWIDTH      = 18,
    parameter int unsigned FRAC_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [3:0][3:0][DATAWIDTH-1:0] i_model,
    input  logic [3:0][3:0][DATAWIDTH-1:0] i_view,
    input  logic [3:0][3:0][DATAWIDTH-1:0] i_proj,
    input  logic                           i_vp_dirty,
    input  logic                           i_dv,
    output logic                           o_ready,
    output logic [3:0][3:0][DATAWIDTH-1:0] o_mvp,
    output logic                           o_dv,
`ifdef MVP_SEQ_TIMEOUT_EN
    output logic                           o_err,
`endif
    output logic [3:0][3:0][DATAWIDTH-1:0] mul_a,
    output logic [3:0][3:0][DATAWIDTH-1:0] mul_b,
    output logic                           mul_i_dv,
    input  logic [3:0][3:0][DATAWIDTH-1:0] mul_c,
    input  logic                           mul_o_dv,
    input  logic                           mul_o_ready
);

    typedef logic [3:0][3:0][DATAWIDTH-1:0] mat_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_VP,
        WAIT_VP,
        ISSUE_MVP,
        WAIT_MVP,
        DONE
    } state_e;

    // Values are passed through untouched; the fixed-point format only has to be sane.
    if (FRAC_BITS >= DATAWIDTH || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("mvp_matrix_sequencer: FRAC_BITS must be below DATAWIDTH and TIMEOUT_CYCLES nonzero");
    end

    state_e state;
    state_e state_nxt;
    mat_t   m_reg;
    mat_t   v_reg;
    mat_t   p_reg;
    mat_t   vp_reg;
    logic   vp_valid;
    logic   seen_busy;
    logic   in_wait;
    logic   mul_done;
    logic   timeout;

    assign in_wait = (state == WAIT_VP) || (state == WAIT_MVP);

    // A stale-high mul_o_dv only counts once the multiplier has been seen busy.
    assign mul_done = in_wait && seen_busy && mul_o_ready && mul_o_dv;

`ifdef MVP_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    assign timeout = in_wait && !mul_done && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counts cycles spent in a WAIT state; zero on every WAIT entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_cnt <= '0;
        end else if (in_wait) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (i_dv) state_nxt = (i_vp_dirty || !vp_valid) ? ISSUE_VP : ISSUE_MVP;
            ISSUE_VP:  if (mul_o_ready) state_nxt = WAIT_VP;
            WAIT_VP: begin
                if (mul_done) begin
                    state_nxt = ISSUE_MVP;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            ISSUE_MVP: if (mul_o_ready) state_nxt = WAIT_MVP;
            WAIT_MVP: begin
                if (mul_done) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Operands are held through WAIT so the multiplier may sample them late.
    always_comb begin
        o_ready  = 1'b0;
        o_dv     = 1'b0;
        mul_i_dv = 1'b0;
        mul_a    = '0;
        mul_b    = '0;
`ifdef MVP_SEQ_TIMEOUT_EN
        o_err    = timeout;
`endif
        case (state)
            IDLE:      o_ready = 1'b1;
            ISSUE_VP: begin
                mul_a    = p_reg;
                mul_b    = v_reg;
                mul_i_dv = mul_o_ready;
            end
            WAIT_VP: begin
                mul_a = p_reg;
                mul_b = v_reg;
            end
            ISSUE_MVP: begin
                mul_a    = vp_reg;
                mul_b    = m_reg;
                mul_i_dv = mul_o_ready;
            end
            WAIT_MVP: begin
                mul_a = vp_reg;
                mul_b = m_reg;
            end
            DONE:      o_dv = 1'b1;
            default:   o_dv = 1'b0;
        endcase
    end

    // Job operands, P*V cache and result capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_reg     <= '0;
            v_reg     <= '0;
            p_reg     <= '0;
            vp_reg    <= '0;
            vp_valid  <= 1'b0;
            seen_busy <= 1'b0;
            o_mvp     <= '0;
        end else begin
            if (state == IDLE && i_dv) begin
                m_reg <= i_model;
                v_reg <= i_view;
                p_reg <= i_proj;
            end
            if (!in_wait || mul_done) begin
                seen_busy <= 1'b0;
            end else if (!mul_o_ready) begin
                seen_busy <= 1'b1;
            end
            if (state == WAIT_VP && mul_done) begin
                vp_reg   <= mul_c;
                vp_valid <= 1'b1;
            end
            if (state == WAIT_MVP && mul_done) begin
                o_mvp <= mul_c;
            end
            if (timeout) begin
                vp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mvp_matrix_sequencer.sv
// Bench for mvp_matrix_sequencer: behavioural 4x4 fixed-point multiplier plus a job-level
// reference model (P*V cache, handshake latency arithmetic); directed table, corner sequences, random jobs.
module tb_mvp_matrix_sequencer;

    localparam int unsigned DW = 18;
    localparam int unsigned FB = 8;

    typedef logic [3:0][3:0][DW-1:0] mat_t;

    typedef struct {
        mat_t m;
        mat_t v;
        mat_t p;
        logic dirty;
        int   lat;
        int   stall;
        int   n_iss;
        int   iss0;
        int   iss1;
        int   dv;
        mat_t a_last;
        mat_t mvp;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    mat_t i_model, i_view, i_proj;
    logic i_vp_dirty, i_dv;
    logic o_ready, o_dv;
    mat_t o_mvp;
    mat_t mul_a, mul_b, mul_c;
    logic mul_i_dv, mul_o_dv, mul_o_ready;
`ifdef MVP_SEQ_TIMEOUT_EN
    logic o_err;
`endif

    mvp_matrix_sequencer #(
        .DATAWIDTH      (DW),
        .FRAC_BITS      (FB),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_model     (i_model),
        .i_view      (i_view),
        .i_proj      (i_proj),
        .i_vp_dirty  (i_vp_dirty),
        .i_dv        (i_dv),
        .o_ready     (o_ready),
        .o_mvp       (o_mvp),
        .o_dv        (o_dv),
`ifdef MVP_SEQ_TIMEOUT_EN
        .o_err       (o_err),
`endif
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_i_dv    (mul_i_dv),
        .mul_c       (mul_c),
        .mul_o_dv    (mul_o_dv),
        .mul_o_ready (mul_o_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic mat_t matmul(input mat_t a, input mat_t b);
        mat_t r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                longint acc = 0;
                for (int k = 0; k < 4; k++) begin
                    acc += longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
                end
                r[i][j] = DW'(acc >>> FB);
            end
        end
        return r;
    endfunction

    function automatic mat_t diag(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] c, input logic [DW-1:0] d);
        mat_t r = '0;
        r[0][0] = a;
        r[1][1] = b;
        r[2][2] = c;
        r[3][3] = d;
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[i][j] = DW'($urandom);
            end
        end
        return r;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural multiplier: optional ready-high pre-delay, L-1 busy cycles, result for one cycle.
    int   cyc       = 0;
    int   mdl_lat   = 6;
    int   mdl_pre   = 0;
    bit   mdl_stale = 1'b0;
    int   stall_lo  = 0;
    int   stall_hi  = -1;
    int   m_phase   = 0;
    int   m_cnt     = 0;
    mat_t m_res;
    mat_t m_c;
    logic m_odv;

    always @(posedge clk) cyc <= cyc + 1;

    assign mul_o_ready = (m_phase != 2) && !(cyc >= stall_lo && cyc <= stall_hi);
    assign mul_o_dv    = m_odv;
    assign mul_c       = m_c;

    always @(posedge clk) begin
        if (!rstn) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_odv   <= 1'b0;
            m_c     <= '0;
        end else begin
            case (m_phase)
                0: begin
                    m_odv <= mdl_stale;
                    m_c   <= '0;
                    if (mul_i_dv && mul_o_ready) begin
                        m_res <= matmul(mul_a, mul_b);
                        if (mdl_pre > 0) begin
                            m_phase <= 1;
                            m_cnt   <= mdl_pre;
                        end else begin
                            m_phase <= 2;
                            m_cnt   <= mdl_lat - 1;
                        end
                    end
                end
                1: begin
                    if (m_cnt == 1) begin
                        m_phase <= 2;
                        m_cnt   <= mdl_lat - 1;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    if (m_cnt == 1) begin
                        m_phase <= 0;
                        m_odv   <= 1'b1;
                        m_c     <= m_res;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
            endcase
        end
    end

    // Observations of one job, indexed by cycles after the accept cycle.
    int   n_iss;
    int   iss_cyc [2];
    mat_t iss_a   [2];
    mat_t iss_b   [2];
    int   dv_cyc;
    int   n_dv;
    mat_t dv_mvp;
    int   rdy_after;
    int   ops_zero;

    task automatic run_job(input mat_t m, input mat_t v, input mat_t p, input logic dirty,
                           input int stall, input int poke, input int abort_at, input int budget);
        int c0;
        n_iss = 0; n_dv = 0; dv_cyc = -1; rdy_after = 0; ops_zero = 0; dv_mvp = '0;
        for (int i = 0; i < 2; i++) begin
            iss_cyc[i] = -1; iss_a[i] = '0; iss_b[i] = '0;
        end
        @(negedge clk);
        i_model = m; i_view = v; i_proj = p; i_vp_dirty = dirty; i_dv = 1'b1;
        c0 = cyc;
        stall_lo = c0 + 1;
        stall_hi = c0 + stall;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            i_dv = (k == poke);
            if (k == abort_at) rstn = 1'b0;
            if (k == abort_at + 2) rstn = 1'b1;
            if (mul_i_dv === 1'b1) begin
                if (n_iss < 2) begin
                    iss_cyc[n_iss] = k; iss_a[n_iss] = mul_a; iss_b[n_iss] = mul_b;
                end
                n_iss++;
            end
            if (dv_cyc >= 0 && k == dv_cyc + 1) begin
                rdy_after = int'(o_ready);
                ops_zero  = int'(mul_a == '0 && mul_b == '0);
            end
            if (o_dv === 1'b1) begin
                n_dv++;
                if (dv_cyc < 0) begin
                    dv_cyc = k; dv_mvp = o_mvp;
                end
            end
            if (dv_cyc >= 0 && k >= dv_cyc + 3) break;
        end
        i_dv = 1'b0;
        rstn = 1'b1;
    endtask

    // Job-level reference: P*V cache validity and latency from the handshake arithmetic.
    bit   ref_valid = 1'b0;
    mat_t ref_pv    = '0;

    task automatic ref_job(input string tag, input mat_t m, input mat_t v, input mat_t p,
                           input logic dirty, input int stall, input int poke);
        bit   full;
        mat_t pv;
        int   lt, iss0, exp_dv, last;
        full   = dirty || !ref_valid;
        pv     = full ? matmul(p, v) : ref_pv;
        lt     = mdl_lat + mdl_pre;
        iss0   = 1 + stall;
        exp_dv = full ? iss0 + 2 * lt + 2 : iss0 + lt + 1;
        last   = full ? 1 : 0;
        run_job(m, v, p, dirty, stall, poke, -1, exp_dv + 8);
        chk_int({tag, ".n_issue"}, n_iss, full ? 2 : 1);
        chk_int({tag, ".issue0_cyc"}, iss_cyc[0], iss0);
        if (full) begin
            chk_mat({tag, ".vp_a"}, iss_a[0], p);
            chk_mat({tag, ".vp_b"}, iss_b[0], v);
            chk_int({tag, ".issue1_cyc"}, iss_cyc[1], iss0 + lt + 1);
        end
        chk_mat({tag, ".mvp_a"}, iss_a[last], pv);
        chk_mat({tag, ".mvp_b"}, iss_b[last], m);
        chk_int({tag, ".dv_cyc"}, dv_cyc, exp_dv);
        chk_int({tag, ".n_dv"}, n_dv, 1);
        chk_mat({tag, ".o_mvp"}, dv_mvp, matmul(pv, m));
        chk_int({tag, ".ready_after"}, rdy_after, 1);
        chk_int({tag, ".ops_idle_zero"}, ops_zero, 1);
        if (full) begin
            ref_pv    = pv;
            ref_valid = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1, "time limit");
    end

    vec_t tbl [4];

    initial begin
        mat_t ident, vmat, m0, e0, m2, e2, p3, pv3;

        ident = diag(18'h100, 18'h100, 18'h100, 18'h100);
        vmat  = ident;  vmat[0][3] = 18'h300;
        m0    = diag(18'h200, 18'h200, 18'h200, 18'h100);
        e0    = m0;     e0[0][3]   = 18'h300;
        m2    = diag(18'h100, 18'h100, 18'h100, 18'h200);
        e2    = m2;     e2[0][3]   = 18'h600;
        p3    = diag(18'h200, 18'h200, 18'h200, 18'h200);
        pv3   = p3;     pv3[0][3]  = 18'h600;

        tbl[0] = '{m: m0,    v: vmat, p: ident, dirty: 1'b1, lat: 6, stall: 0,
                   n_iss: 2, iss0: 1, iss1: 8,  dv: 15, a_last: vmat, mvp: e0};
        tbl[1] = '{m: ident, v: vmat, p: ident, dirty: 1'b0, lat: 6, stall: 0,
                   n_iss: 1, iss0: 1, iss1: -1, dv: 8,  a_last: vmat, mvp: vmat};
        tbl[2] = '{m: m2,    v: vmat, p: ident, dirty: 1'b0, lat: 3, stall: 2,
                   n_iss: 1, iss0: 3, iss1: -1, dv: 7,  a_last: vmat, mvp: e2};
        tbl[3] = '{m: ident, v: vmat, p: p3,    dirty: 1'b1, lat: 2, stall: 1,
                   n_iss: 2, iss0: 2, iss1: 5,  dv: 8,  a_last: pv3,  mvp: pv3};

        // Reset with a request pending and the multiplier not ready.
        rstn = 1'b0; i_dv = 1'b1; i_vp_dirty = 1'b1;
        i_model = m0; i_view = vmat; i_proj = ident;
        stall_lo = 0; stall_hi = 3;
        repeat (3) @(negedge clk);
        chk_int("reset.o_ready", int'(o_ready), 1);
        chk_int("reset.o_dv", int'(o_dv), 0);
        chk_int("reset.mul_i_dv", int'(mul_i_dv), 0);
        chk_mat("reset.o_mvp", o_mvp, '0);
        chk_mat("reset.mul_a", mul_a, '0);
        chk_mat("reset.mul_b", mul_b, '0);
        rstn = 1'b1; i_dv = 1'b0;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 4; t++) begin
            string tag;
            tag = $sformatf("vec%0d", t);
            mdl_lat = tbl[t].lat; mdl_pre = 0; mdl_stale = 1'b0;
            run_job(tbl[t].m, tbl[t].v, tbl[t].p, tbl[t].dirty, tbl[t].stall, -1, -1, tbl[t].dv + 8);
            chk_int({tag, ".n_issue"}, n_iss, tbl[t].n_iss);
            chk_int({tag, ".issue0_cyc"}, iss_cyc[0], tbl[t].iss0);
            if (tbl[t].n_iss == 2) chk_int({tag, ".issue1_cyc"}, iss_cyc[1], tbl[t].iss1);
            chk_mat({tag, ".mvp_a"}, iss_a[tbl[t].n_iss - 1], tbl[t].a_last);
            chk_int({tag, ".dv_cyc"}, dv_cyc, tbl[t].dv);
            chk_mat({tag, ".o_mvp"}, dv_mvp, tbl[t].mvp);
            chk_int({tag, ".ready_after"}, rdy_after, 1);
            ref_pv = tbl[t].a_last; ref_valid = 1'b1;
        end

        // Stale-high mul_o_dv with a ready-high gap before busy, and an i_dv pulse in WAIT_VP.
        mdl_lat = 4; mdl_pre = 2; mdl_stale = 1'b1;
        ref_job("stale_poke", rand_mat(), rand_mat(), rand_mat(), 1'b1, 0, 3);

        // Reset in WAIT_MVP aborts and invalidates the cached P*V.
        mdl_lat = 4; mdl_pre = 0; mdl_stale = 1'b0;
        run_job(m0, vmat, ident, 1'b1, 0, -1, 8, 20);
        chk_int("abort.n_dv", n_dv, 0);
        chk_int("abort.n_issue", n_iss, 2);
        ref_valid = 1'b0;
        ref_job("after_abort", rand_mat(), rand_mat(), rand_mat(), 1'b0, 0, -1);

        for (int r = 0; r < 24; r++) begin
            mdl_lat   = int'($urandom_range(2, 7));
            mdl_pre   = int'($urandom_range(0, 2));
            mdl_stale = 1'($urandom_range(0, 1));
            ref_job($sformatf("rand%0d", r), rand_mat(), rand_mat(), rand_mat(),
                    1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), -1);
        end

`ifdef MVP_SEQ_TIMEOUT_EN
        begin : timeout_seq
            int err_cyc, n_err, rdy_err, dv_cnt;
            err_cyc = -1; n_err = 0; rdy_err = 0; dv_cnt = 0;
            mdl_lat = 1000; mdl_pre = 0; mdl_stale = 1'b0;
            @(negedge clk);
            i_model = m0; i_view = vmat; i_proj = ident; i_vp_dirty = 1'b1; i_dv = 1'b1;
            stall_lo = 1; stall_hi = 0;
            for (int k = 1; k <= 80; k++) begin
                @(negedge clk);
                i_dv = 1'b0;
                if (err_cyc >= 0 && k == err_cyc + 1) rdy_err = int'(o_ready);
                if (o_dv === 1'b1) dv_cnt++;
                if (o_err === 1'b1) begin
                    n_err++;
                    if (err_cyc < 0) err_cyc = k;
                end
            end
            chk_int("timeout.err_cyc", err_cyc, 66);
            chk_int("timeout.n_err", n_err, 1);
            chk_int("timeout.ready_after", rdy_err, 1);
            chk_int("timeout.n_dv", dv_cnt, 0);
            rstn = 1'b0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            ref_valid = 1'b0;
            mdl_lat = 3;
            ref_job("after_timeout", rand_mat(), rand_mat(), rand_mat(), 1'b0, 0, -1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
